// File: rtl/flash_pkg.sv
// Shared constants and types for the flash line-fill arbiter and its round-robin helper.
package flash_pkg;

  localparam logic [23:0] FLASH_BASE      = 24'h050000;
  localparam logic [19:0] CPU_ADDR_MAX    = 20'hAFFFF;
  localparam logic [7:0]  SPI_READ_OPCODE = 8'h03;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} fill_state_t;
  typedef enum logic {REQ_IC, REQ_DC} req_id_t;

  // True when the last byte of the line lies beyond the legal CPU window.
  function automatic logic line_out_of_range(input logic [19:0] base,
                                             input logic [20:0] line_bytes,
                                             input logic [19:0] addr_max);
    logic [20:0] last_byte;
    last_byte = {1'b0, base} + line_bytes - 21'd1;
    return last_byte > {1'b0, addr_max};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; remembers the last grant and alternates on contention.
module rr_arbiter2
  import flash_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_ic,
  input  logic    req_dc,
  input  logic    update,
  input  req_id_t update_id,
  output req_id_t grant_id,
  output logic    grant_any
);

  req_id_t last_q;
  req_id_t last_d;

  always_comb begin
    last_d = last_q;
    if (update) last_d = update_id;
  end

  // Reset to "dcache granted last" so the icache wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= REQ_DC;
    else        last_q <= last_d;
  end

  always_comb begin
    grant_any = req_ic | req_dc;
    grant_id  = REQ_IC;
    if (req_ic && req_dc) grant_id = (last_q == REQ_IC) ? REQ_DC : REQ_IC;
    else if (req_dc)      grant_id = REQ_DC;
  end

endmodule

// File: rtl/flash_fill_arbiter.sv
// Shares one SPI read engine between icache and dcache line fills; translates CPU to flash addresses.
// Handshake: *_req is a level held until the one-cycle *_ack; every other output is a one-cycle pulse.
module flash_fill_arbiter #(
  parameter int unsigned LINE_WORDS   = 4,
  parameter logic [23:0] FLASH_BASE   = flash_pkg::FLASH_BASE,
  parameter logic [19:0] CPU_ADDR_MAX = flash_pkg::CPU_ADDR_MAX
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ic_req,
  input  logic [19:0] ic_addr,
  output logic        ic_ack,
  output logic        ic_valid,
  output logic [31:0] ic_data,
  output logic        ic_last,
  output logic        ic_err,
  input  logic        dc_req,
  input  logic [19:0] dc_addr,
  output logic        dc_ack,
  output logic        dc_valid,
  output logic [31:0] dc_data,
  output logic        dc_last,
  output logic        dc_err,
  output logic        spi_start,
  output logic [23:0] spi_addr,
  input  logic        spi_done,
  input  logic [31:0] spi_data
);
  import flash_pkg::*;

  localparam int unsigned       CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [20:0]       LINE_BYTES = 21'(LINE_WORDS * 4);
  localparam logic [19:0]       LINE_MASK  = ~20'(LINE_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(LINE_WORDS - 1);

  fill_state_t      state_q, state_d;
  req_id_t          win_q, win_d;
  logic [19:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ic_ack_q, ic_ack_d, ic_valid_q, ic_valid_d, ic_last_q, ic_last_d, ic_err_q, ic_err_d;
  logic             dc_ack_q, dc_ack_d, dc_valid_q, dc_valid_d, dc_last_q, dc_last_d, dc_err_q, dc_err_d;
  logic [31:0]      ic_data_q, ic_data_d, dc_data_q, dc_data_d;
  logic             spi_start_q, spi_start_d;
  logic [23:0]      spi_addr_q, spi_addr_d;

  req_id_t          grant_id;
  logic             grant_any;
  logic [19:0]      cand_base;
  logic             cand_oob;
  logic [CNT_W-1:0] cnt_nxt;

  rr_arbiter2 u_rr (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req_ic    (ic_req),
    .req_dc    (dc_req),
    .update    (state_q == CHECK),
    .update_id (win_q),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Flash address of word cnt within the line; 20-bit sum, top nibble forced to zero.
  function automatic logic [23:0] fill_addr(input logic [19:0] base, input logic [CNT_W-1:0] cnt);
    logic [19:0] off;
    off = 20'(cnt) << 2;
    return {4'h0, base + off + FLASH_BASE[19:0]};
  endfunction

  assign cand_base = ((grant_id == REQ_IC) ? ic_addr : dc_addr) & LINE_MASK;
  assign cand_oob  = line_out_of_range(cand_base, LINE_BYTES, CPU_ADDR_MAX);
  assign cnt_nxt   = CNT_W'(cnt_q + 1'b1);

  // Outputs are registered on the transition into the state they belong to.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    ic_ack_d    = 1'b0;
    ic_valid_d  = 1'b0;
    ic_last_d   = 1'b0;
    ic_err_d    = 1'b0;
    dc_ack_d    = 1'b0;
    dc_valid_d  = 1'b0;
    dc_last_d   = 1'b0;
    dc_err_d    = 1'b0;
    ic_data_d   = ic_data_q;
    dc_data_d   = dc_data_q;
    spi_start_d = 1'b0;
    spi_addr_d  = spi_addr_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          win_d    = grant_id;
          base_d   = cand_base;
          state_d  = CHECK;
          ic_ack_d = (grant_id == REQ_IC);
          dc_ack_d = (grant_id == REQ_DC);
          ic_err_d = (grant_id == REQ_IC) && cand_oob;
          dc_err_d = (grant_id == REQ_DC) && cand_oob;
        end
      end
      CHECK: begin
        if (line_out_of_range(base_q, LINE_BYTES, CPU_ADDR_MAX)) begin
          state_d = IDLE;
        end else begin
          state_d     = ISSUE;
          spi_start_d = 1'b1;
          spi_addr_d  = fill_addr(base_q, '0);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (spi_done) begin
          state_d = RESP;
          if (win_q == REQ_IC) begin
            ic_data_d  = spi_data;
            ic_valid_d = 1'b1;
            ic_last_d  = (cnt_q == LAST_WORD);
          end else begin
            dc_data_d  = spi_data;
            dc_valid_d = 1'b1;
            dc_last_d  = (cnt_q == LAST_WORD);
          end
        end
      end
      RESP: begin
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_nxt;
          state_d     = ISSUE;
          spi_start_d = 1'b1;
          spi_addr_d  = fill_addr(base_q, cnt_nxt);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      win_q       <= REQ_IC;
      base_q      <= '0;
      cnt_q       <= '0;
      ic_ack_q    <= 1'b0;
      ic_valid_q  <= 1'b0;
      ic_last_q   <= 1'b0;
      ic_err_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      dc_valid_q  <= 1'b0;
      dc_last_q   <= 1'b0;
      dc_err_q    <= 1'b0;
      ic_data_q   <= '0;
      dc_data_q   <= '0;
      spi_start_q <= 1'b0;
      spi_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      ic_ack_q    <= ic_ack_d;
      ic_valid_q  <= ic_valid_d;
      ic_last_q   <= ic_last_d;
      ic_err_q    <= ic_err_d;
      dc_ack_q    <= dc_ack_d;
      dc_valid_q  <= dc_valid_d;
      dc_last_q   <= dc_last_d;
      dc_err_q    <= dc_err_d;
      ic_data_q   <= ic_data_d;
      dc_data_q   <= dc_data_d;
      spi_start_q <= spi_start_d;
      spi_addr_q  <= spi_addr_d;
    end
  end

  assign ic_ack    = ic_ack_q;
  assign ic_valid  = ic_valid_q;
  assign ic_data   = ic_data_q;
  assign ic_last   = ic_last_q;
  assign ic_err    = ic_err_q;
  assign dc_ack    = dc_ack_q;
  assign dc_valid  = dc_valid_q;
  assign dc_data   = dc_data_q;
  assign dc_last   = dc_last_q;
  assign dc_err    = dc_err_q;
  assign spi_start = spi_start_q;
  assign spi_addr  = spi_addr_q;

endmodule

// File: doc/flash_fill_arbiter.md
Name: flash_fill_arbiter

Overview:
- Shares the single SPI flash read engine between the instruction-cache and data-cache miss paths.
- Arbitrates round-robin and translates 20-bit CPU addresses to 24-bit flash addresses (+0x50000, upper 4 bits zero).
- Sequences a LINE_WORDS-word cache-line fill as back-to-back 32-bit SPI reads.
- Routes each returned word to the granted cache. Sits between both cache controllers and the SPI read engine.

Parameters:
- LINE_WORDS, 4: 32-bit words per line fill; power of two, 1..16.
- FLASH_BASE, 24'h050000: offset added to CPU address.
- CPU_ADDR_MAX, 20'hAFFFF: highest legal CPU byte address.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- ic_req  in  1  icache miss request, held until ic_ack
- ic_addr  in  20  icache miss byte address
- ic_ack  out  1  one-cycle grant pulse
- ic_valid  out  1  ic_data valid this cycle
- ic_data  out  32  returned word
- ic_last  out  1  with ic_valid: final word of line
- ic_err  out  1  one-cycle pulse: line out of range, no fill
- dc_req, dc_addr, dc_ack, dc_valid, dc_data, dc_last, dc_err  as ic_* for the dcache
- spi_start  out  1  one-cycle pulse: begin 32-bit read at spi_addr
- spi_addr  out  24  flash byte address, stable from spi_start until spi_done
- spi_done  in  1  one-cycle pulse: spi_data valid
- spi_data  in  32  word read from flash

Behaviour:
- Reset (RST_N=0 at a CLK edge): state IDLE; all outputs 0; spi_addr 0; word counter 0; round-robin pointer favours icache. Reset mid-burst abandons the fill; a later spi_done is ignored while in IDLE.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - Sample ic_req/dc_req; if none, stay.
  - Single request wins. Both: winner is the requester not granted last.
  - Latch winner id and line base = addr with low log2(LINE_WORDS*4) bits cleared.
  - Go to CHECK.
- CHECK (1 cycle): assert the winner's *_ack.
  - base + LINE_WORDS*4 - 1 > CPU_ADDR_MAX: assert the winner's *_err in the same cycle, go IDLE.
  - Otherwise: go ISSUE.
  - Round-robin pointer updates on every ack, including error cases.
- ISSUE: spi_start=1 for exactly one cycle; spi_addr = {4'h0, base + 4*word_cnt + FLASH_BASE[19:0]}, computed in 20 bits (no overflow for legal addresses). Go WAIT.
- WAIT:
  - Hold spi_addr.
  - On spi_done: register spi_data into the winner's *_data, go RESP.
  - spi_done in any other state is ignored.
- RESP (1 cycle):
  - Winner's *_valid=1; *_last=1 iff word_cnt==LINE_WORDS-1.
  - If last: clear word_cnt, go IDLE. Otherwise: increment word_cnt, go ISSUE.
- Latency:
  - Request to ack: 2 cycles.
  - ack to first spi_start: 1 cycle.
  - spi_done to valid: 1 cycle.
  - Minimum gap between words: 2 cycles plus SPI latency.
- The non-granted requester keeps req high; it is served on the next IDLE. The granted requester deasserts req by the cycle after ack, otherwise a second fill follows.
- *_data holds its last value between valids. The non-winner's valid/last/err outputs stay 0.

Decomposition:
- Package flash_pkg:
  - constants FLASH_BASE, CPU_ADDR_MAX, SPI_READ_OPCODE (8'h03);
  - typedef enum fill_state_t {IDLE, CHECK, ISSUE, WAIT, RESP};
  - typedef enum req_id_t {REQ_IC, REQ_DC}.
- Sub-module rr_arbiter2: 2-input round-robin arbiter with last-grant register, synchronous active-low reset, update strobe.

Test Plan:
- Reset, then ic_req=1, ic_addr=0x00014, LINE_WORDS=4 -> ic_ack 2 cycles later. spi_addr sequence 0x050010, 0x050014, 0x050018, 0x05001C. Four ic_valid pulses carrying the spi_data values in order; ic_last only on the 4th. All dc_* stay 0.
- ic_req and dc_req rise in the same cycle after reset -> icache line served first. dc_ack follows the icache last word by 2 cycles. Then dc_req and a new ic_req raised together -> icache granted next.
- dc_addr=0xAFFF4 -> fill of 0xAFFF0..0xAFFFC, spi_addr 0x0FFFF0..0x0FFFFC. Then dc_addr=0xB0000 -> dc_ack and dc_err together, no spi_start.
- spi_done pulsed while in IDLE and in ISSUE -> no valid output, no state change.
- RST_N=0 for one cycle during WAIT of word 2 -> all outputs 0 next cycle. Subsequent spi_done ignored. A new ic_req starts from word 0 with icache priority.
- LINE_WORDS=1, dc_addr=0x00003 -> single spi_addr 0x050000. One dc_valid with dc_last=1.
